// File: rtl/ltc2308_spi_responder.sv
// LTC2308 ADC emulator: SPI responder sampling the initiator's CONVST/SCK/SDI pins on the
// system clock, with conversion results taken from a host-loaded 8-channel value table.
module ltc2308_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  addr,
  input  logic        write,
  input  logic [31:0] writedatain,
  input  logic        read,
  output logic [31:0] readdataout,
  input  logic        ADC_CONVST_i,
  input  logic        ADC_SCK_i,
  input  logic        ADC_SDI_i,
  output logic        ADC_SDO_o,
  output logic [1:0]  dbg_state_o
);
  localparam int               CNT_W     = $clog2(CONV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [5:0]       CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_READY, ST_SHIFT} state_e;

  // Host bus: write/read are single-cycle strobes with no backpressure; a read strobe
  // sampled on a clock edge loads readdataout on that same edge (visible the cycle after).

  logic [SYNC_STAGES-1:0] convst_sync_q, convst_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   convst_prev_q, sck_prev_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      result_sr_q, result_sr_d;
  logic [5:0]       cfg_sr_q, cfg_sr_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [3:0]       fallcnt_q, fallcnt_d;
  logic [5:0]       pending_cfg_q, pending_cfg_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             diff_q, diff_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;
  logic             sdo_q, sdo_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [11:0]      chan_val_q [8];
  logic [11:0]      chan_val_d [8];

  logic        convst_s, sck_s, sdi_s;
  logic        convst_rise, sck_rise, sck_fall;
  logic [2:0]  conv_sel;
  logic [11:0] conv_value;
  logic [31:0] status_word;

  assign convst_s    = convst_sync_q[SYNC_STAGES-1];
  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign convst_rise = convst_s & ~convst_prev_q;
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;

  // cfg = {S/D, O/S, S1, S0, UNI, SLP}; channel number is {S1, S0, O/S}
  assign conv_sel    = {pending_cfg_q[3], pending_cfg_q[2], pending_cfg_q[4]};
  assign conv_value  = pending_cfg_q[5] ? chan_val_q[conv_sel] : 12'h000;
  assign status_word = {frame_count_q, 2'b00, pending_cfg_q, 5'b00000,
                        diff_q, abort_q, overrun_q};

  always_comb begin
    convst_sync_d = {convst_sync_q[SYNC_STAGES-2:0], ADC_CONVST_i};
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], ADC_SCK_i};
    sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], ADC_SDI_i};

    state_d       = state_q;
    cnt_d         = cnt_q;
    result_sr_d   = result_sr_q;
    cfg_sr_d      = cfg_sr_q;
    bitcnt_d      = bitcnt_q;
    fallcnt_d     = fallcnt_q;
    pending_cfg_d = pending_cfg_q;
    frame_count_d = frame_count_q;
    diff_d        = diff_q;
    abort_d       = abort_q;
    overrun_d     = overrun_q;
    sdo_d         = sdo_q;
    readdata_d    = readdata_q;
    chan_val_d    = chan_val_q;

    if (write && !addr[3]) chan_val_d[addr[2:0]] = writedatain[11:0];
    // Clear is applied first so a flag set by the FSM in the same clock survives.
    if (write && (addr == 4'd8) && writedatain[0]) begin
      diff_d    = 1'b0;
      abort_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (read) begin
      if (!addr[3])            readdata_d = {20'b0, chan_val_q[addr[2:0]]};
      else if (addr == 4'd8)   readdata_d = status_word;
      else                     readdata_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (convst_rise) begin
          result_sr_d = conv_value;
          if (!pending_cfg_q[5]) diff_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sdo_d = 1'b0;
        if (sck_rise || sck_fall) overrun_d = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_READY;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_READY: begin
        sdo_d     = result_sr_q[11];
        bitcnt_d  = 4'd0;
        fallcnt_d = 4'd0;
        cfg_sr_d  = 6'b0;
        if (!convst_s && sck_rise) begin
          cfg_sr_d = {5'b0, sdi_s};
          bitcnt_d = 4'd1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (convst_rise) begin
          // Abort: the partial config is dropped and a fresh conversion starts.
          abort_d     = 1'b1;
          result_sr_d = conv_value;
          if (!pending_cfg_q[5]) diff_d = 1'b1;
          cnt_d       = '0;
          sdo_d       = 1'b0;
          state_d     = ST_CONV;
        end else if (sck_rise) begin
          if (bitcnt_q < 4'd6)   cfg_sr_d = {cfg_sr_q[4:0], sdi_s};
          if (bitcnt_q != 4'hF)  bitcnt_d = bitcnt_q + 4'd1;
        end else if (sck_fall) begin
          result_sr_d = {result_sr_q[10:0], 1'b0};
          if (fallcnt_q == 4'd11) begin
            pending_cfg_d = cfg_sr_q;
            frame_count_d = frame_count_q + 16'd1;
            sdo_d         = 1'b0;
            state_d       = ST_IDLE;
          end else begin
            fallcnt_d = fallcnt_q + 4'd1;
            sdo_d     = result_sr_q[10];
          end
        end
      end
      default: begin
        sdo_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync_q <= '0;
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      convst_prev_q <= 1'b0;
      sck_prev_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      result_sr_q   <= '0;
      cfg_sr_q      <= '0;
      bitcnt_q      <= '0;
      fallcnt_q     <= '0;
      pending_cfg_q <= CFG_RESET;
      frame_count_q <= '0;
      diff_q        <= 1'b0;
      abort_q       <= 1'b0;
      overrun_q     <= 1'b0;
      sdo_q         <= 1'b0;
      readdata_q    <= '0;
      chan_val_q    <= '{default: '0};
    end else begin
      convst_sync_q <= convst_sync_d;
      sck_sync_q    <= sck_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      convst_prev_q <= convst_s;
      sck_prev_q    <= sck_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      result_sr_q   <= result_sr_d;
      cfg_sr_q      <= cfg_sr_d;
      bitcnt_q      <= bitcnt_d;
      fallcnt_q     <= fallcnt_d;
      pending_cfg_q <= pending_cfg_d;
      frame_count_q <= frame_count_d;
      diff_q        <= diff_d;
      abort_q       <= abort_d;
      overrun_q     <= overrun_d;
      sdo_q         <= sdo_d;
      readdata_q    <= readdata_d;
      chan_val_q    <= chan_val_d;
    end
  end

  assign readdataout = readdata_q;
  assign ADC_SDO_o   = sdo_q;
  assign dbg_state_o = state_q;

endmodule
